// File: rtl/cont_assign_checker.sv
// Checks a 3-in/4-out combinational DUT against parameter truth tables.
// One vector at a time: accept, wait SETTLE clocks, compare, then count and log the first failure.
module cont_assign_checker #(
  parameter logic [7:0] TT_W    = 8'h00,
  parameter logic [7:0] TT_X    = 8'h00,
  parameter logic [7:0] TT_Y    = 8'h00,
  parameter logic [7:0] TT_Z    = 8'h00,
  parameter int         SETTLE  = 2,
  parameter int         NUM_VEC = 3,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             w,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [3:0]       first_fail_obs,
  output logic             done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_COMPARE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // vec_cnt is wide enough to hold NUM_VEC itself, so the end test never sees a wrapped value.
  localparam int VC_NEED = $clog2(NUM_VEC + 1);
  localparam int VC_W    = (VC_NEED > CNT_W) ? VC_NEED : CNT_W;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [VC_W-1:0]  NUM_VEC_L   = VC_W'(NUM_VEC);

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       settle_q, settle_d;
  logic [VC_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [3:0]       ff_obs_q, ff_obs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0] expected;
  logic [3:0] observed;

  always_comb begin
    // NOTE: every variable gets a hold-value default before the case, so no path can infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    vec_cnt_d  = vec_cnt_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    err_d      = err_q;
    ff_idx_d   = ff_idx_q;
    ff_obs_d   = ff_obs_q;

    expected = {TT_W[idx_q], TT_X[idx_q], TT_Y[idx_q], TT_Z[idx_q]};
    observed = {w, x, y, z};

    case (state_q)
      S_IDLE: begin
        if (vec_valid) begin
          idx_d    = {a, b, c};
          settle_d = SETTLE_LOAD;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == 4'd0) state_d = S_COMPARE;
        else                  settle_d = settle_q - 4'd1;
      end
      S_COMPARE: begin
        vec_cnt_d = vec_cnt_q + VC_W'(1);
        if (observed == expected) begin
          if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end else begin
          if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
          err_d = 1'b1;
          // err_q still clear means this is the first mismatch of the run.
          if (!err_q) begin
            ff_idx_d = CNT_W'(vec_cnt_q);
            ff_obs_d = observed;
          end
        end
        state_d = (vec_cnt_d == NUM_VEC_L) ? S_DONE : S_IDLE;
      end
      default: ;
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_COMPARE);
    done_d = (state_d == S_DONE);
  end

  // NOTE: reset is asynchronous; all state including idx_q clears the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      settle_q   <= '0;
      vec_cnt_q  <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
      ff_idx_q   <= '0;
      ff_obs_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      vec_cnt_q  <= vec_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_q      <= err_d;
      ff_idx_q   <= ff_idx_d;
      ff_obs_q   <= ff_obs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy           = busy_q;
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign err            = err_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_obs = ff_obs_q;
  assign done           = done_q;

endmodule

// File: doc/cont_assign_checker.md
CONT_ASSIGN_CHECKER -- requirements
Module: cont_assign_checker

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- TT_W, 8'h00, expected-w truth table indexed by {a,b,c}.
- TT_X, 8'h00, expected-x truth table indexed by {a,b,c}.
- TT_Y, 8'h00, expected-y truth table indexed by {a,b,c}.
- TT_Z, 8'h00, expected-z truth table indexed by {a,b,c}.
- SETTLE, 2, clocks waited before sampling DUT outputs (legal range 1..15).
- NUM_VEC, 3, vectors per run.
- CNT_W, 8, counter width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous reset, active-high.
- vec_valid, in, 1, stimulus vector applied this cycle.
- a, in, 1, stimulus bit.
- b, in, 1, stimulus bit.
- c, in, 1, stimulus bit.
- w, in, 1, DUT response bit.
- x, in, 1, DUT response bit.
- y, in, 1, DUT response bit.
- z, in, 1, DUT response bit.
- busy, out, 1, vector in flight.
- pass_cnt, out, CNT_W, matching vectors.
- fail_cnt, out, CNT_W, mismatching vectors.
- err, out, 1, sticky mismatch flag.
- first_fail_idx, out, CNT_W, vector index of first mismatch.
- first_fail_obs, out, 4, {w,x,y,z} observed at first mismatch.
- done, out, 1, NUM_VEC vectors checked.

REQ-003 There SHALL be one clock (clk) and one reset (rst), with reset asynchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, SETTLE, COMPARE and DONE.
REQ-005 In IDLE, vec_valid=1 SHALL latch {a,b,c} into idx_q, load the settle counter with SETTLE-1, and move to SETTLE on the next edge.
REQ-006 In SETTLE, the counter SHALL decrement each clock; at 0 the FSM SHALL go to COMPARE.
REQ-007 COMPARE SHALL last exactly 1 cycle: observed {w,x,y,z} is compared with expected {TT_W[idx_q],TT_X[idx_q],TT_Y[idx_q],TT_Z[idx_q]}.
REQ-008 Total latency SHALL be vec_valid edge to counter update = SETTLE+1 clocks.
REQ-009 On a match, pass_cnt SHALL increment; on a mismatch, fail_cnt SHALL increment and err SHALL be set.
REQ-010 On the first mismatch only, first_fail_idx SHALL capture vec_cnt and first_fail_obs SHALL capture {w,x,y,z}; later mismatches SHALL NOT overwrite them.
REQ-011 vec_cnt SHALL increment in COMPARE; when the new value equals NUM_VEC the FSM SHALL go to DONE, otherwise to IDLE.
REQ-012 busy SHALL be 1 in SETTLE and COMPARE and 0 otherwise.
REQ-013 vec_valid SHALL be ignored while busy=1 and in DONE, with no latch and no count.
REQ-014 The stimulus bits a, b and c SHALL be sampled only at acceptance; later changes SHALL NOT alter idx_q.
REQ-015 DONE SHALL be terminal: done=1 is held, counters are frozen, and exit is by rst only.
REQ-016 pass_cnt and fail_cnt SHALL saturate at 2^CNT_W-1 with no wrap; vec_cnt is compared with NUM_VEC before any wrap.
REQ-017 pass_cnt + fail_cnt SHALL always equal vec_cnt when unsaturated.
REQ-018 All outputs SHALL be registered, and no output SHALL depend combinationally on the inputs.

Reset
REQ-019 rst=1 SHALL immediately force state IDLE and set busy, done and err to 0, and pass_cnt, fail_cnt, vec_cnt, first_fail_idx, first_fail_obs and idx_q to 0.
REQ-020 rst asserted mid-vector (in SETTLE or COMPARE) SHALL abort the vector with no count update.
REQ-021 After rst is deasserted, the first accepted vec_valid SHALL be vector index 0.

Verification
REQ-022 All pass (TT_W=8'h88, TT_X=8'hEE, TT_Y=8'h96, TT_Z=8'h11, SETTLE=2): drive the vectors 000, 011, 101 with a DUT model matching the tables -> pass_cnt=3, fail_cnt=0, err=0, done=1 after the third COMPARE.
REQ-023 Injected fault: force w inverted on vector index 1 (abc=011) -> fail_cnt=1, err=1, first_fail_idx=1, first_fail_obs equals the observed {w,x,y,z}; a second forced fault on index 2 leaves first_fail_* unchanged.
REQ-024 Latency: vec_valid pulse at cycle N -> busy=1 from N+1 through N+3, counter change visible at N+3 with SETTLE=2; repeat with SETTLE=1 -> counter change at N+2.
REQ-025 Ignore rules: vec_valid held high for 5 cycles -> exactly 1 vector accepted, and a second pulse while busy -> no effect; vec_valid in DONE -> counters unchanged.
REQ-026 Reset mid-operation: assert rst during SETTLE of vector 2 -> all outputs 0 asynchronously, without waiting for a clk edge, and the next vector is counted as index 0.
REQ-027 Saturation: CNT_W=2, NUM_VEC=6, all vectors matching -> pass_cnt holds at 3, and done=1 after 6 vectors.
